uart_tx_feeder: RTL

Byte-queueing sequencer in front of the serial transmit stage. Accepts 8-bit characters from the host logic at up to one per clock, buffers them in a circular FIFO, and presents them one at a time to the serial transmitter as a data byte plus a one-clock start pulse. It waits for the transmitter's one-clock done pulse, then enforces an inter-byte gap before issuing the next byte. A watchdog recovers the sequencer if the transmitter never reports done.

---
 rtl/uart_tx_feeder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO sequencer feeding a serial transmitter: start/done handshake,
// optional inter-byte gap, and a watchdog that recovers from a silent transmitter.
`timescale 1ns/1ps
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 20000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              clr_err,
  input  logic              tx_done,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [GW-1:0]   GAP_LOAD  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  // Abort on the edge where the timer would reach TIMEOUT-1, i.e. TIMEOUT clocks after START.
  localparam logic [TW-1:0]   TIMER_END = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [TW-1:0]     timer;
  logic [GW-1:0]     gap_cnt;
  logic              push;
  logic              pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = (state == IDLE) && !empty;

  // NOTE: the storage array has no reset; stale bytes are unreachable once the pointers and count clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      timer       <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      // NOTE: the later watchdog set overrides this clear, so a coincident event wins.
      if (clr_err) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (GAP_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end
          end else if (timer == TIMER_END) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
